// File: rtl/gpio_bus_master_pkg.sv
// -----------------------------------------------------------------------------
// gpio_pkg
//   Shared types and helpers for the GPIO register-bus initiator:
//     - gpio_op_e     : host command opcodes (values 6 and 7 are illegal)
//     - gpio_state_e  : initiator FSM states
//     - GPIO_*_ADDR   : register map of the GPIO block
//     - legal_addr()  : address decode against the register map
//     - rmw_value()   : read-modify-write data path for SET/CLR/TOGGLE
//   Helpers work on 64-bit operands so any ADDR_WIDTH/DATA_WIDTH up to 64 can
//   use them through a zero-extending cast.
// -----------------------------------------------------------------------------
package gpio_pkg;

    typedef enum logic [2:0] {
        OP_READ   = 3'd0,
        OP_WRITE  = 3'd1,
        OP_SET    = 3'd2,
        OP_CLR    = 3'd3,
        OP_TOGGLE = 3'd4,
        OP_POLL   = 3'd5
    } gpio_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ADDR,
        ST_RD_CAP,
        ST_WR,
        ST_RSP
    } gpio_state_e;

    localparam logic [63:0] GPIO_IN_ADDR  = 64'h000;
    localparam logic [63:0] GPIO_OUT_ADDR = 64'h004;
    localparam logic [63:0] GPIO_DIR_ADDR = 64'h008;

    function automatic logic legal_addr(input logic [63:0] addr);
        return (addr == GPIO_IN_ADDR) || (addr == GPIO_OUT_ADDR) ||
               (addr == GPIO_DIR_ADDR);
    endfunction

    // New register value for a bit operation applied to the value r just read.
    function automatic logic [63:0] rmw_value(input gpio_op_e op,
                                              input logic [63:0] r,
                                              input logic [63:0] m);
        case (op)
            OP_SET:    return r | m;
            OP_CLR:    return r & ~m;
            OP_TOGGLE: return r ^ m;
            default:   return r;
        endcase
    endfunction

endpackage

// File: rtl/gpio_bus_master_if.sv
// -----------------------------------------------------------------------------
// gpio_bus_master_if
//   Bundles the host command channel, the response channel and the GPIO
//   register bus seen by gpio_bus_master.
//     cmd_*    : host command (valid/ready)
//     rsp_*    : response back to the host (valid/ready)
//     ADDRESS/WRITE/WDATA/RDATA : GPIO register bus
//   modport master : the initiator (gpio_bus_master)
//   modport slave  : the environment (command source, response sink and
//                    GPIO register block)
// -----------------------------------------------------------------------------
interface gpio_bus_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [2:0]            cmd_op;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_data;
    logic [DATA_WIDTH-1:0] cmd_mask;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  rsp_err;

    logic [ADDR_WIDTH-1:0] ADDRESS;
    logic                  WRITE;
    logic [DATA_WIDTH-1:0] WDATA;
    logic [DATA_WIDTH-1:0] RDATA;

    modport master (
        input  cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_mask, rsp_ready, RDATA,
        output cmd_ready, rsp_valid, rsp_data, rsp_err, ADDRESS, WRITE, WDATA
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_mask, rsp_ready, RDATA,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err, ADDRESS, WRITE, WDATA
    );
endinterface

// File: rtl/gpio_bus_master.sv
// -----------------------------------------------------------------------------
// gpio_bus_master
//   Initiator for the GPIO register bus. Accepts one host command at a time
//   and turns it into bus writes, 1-cycle-latency bus reads, read-modify-write
//   bit operations or a bounded poll, then returns one response.
//
//   Ports:
//     clk    : clock
//     rst_n  : asynchronous active-low reset
//     bus    : gpio_bus_master_if.master (command, response and register bus)
//
//   Parameters:
//     ADDR_WIDTH, DATA_WIDTH : bus widths (<= 64)
//     POLL_MAX               : poll read iterations before timeout (>= 1)
// -----------------------------------------------------------------------------
module gpio_bus_master
    import gpio_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int POLL_MAX   = 1024
) (
    input  logic                   clk,
    input  logic                   rst_n,
    gpio_bus_master_if.master      bus
);

    localparam int               CNT_W     = $clog2(POLL_MAX + 1);
    localparam logic [CNT_W-1:0] POLL_LAST = CNT_W'(POLL_MAX - 1);

    gpio_state_e           state_q, state_d;
    logic [2:0]            op_q, op_d;
    logic [DATA_WIDTH-1:0] mask_q, mask_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] address_q, address_d;
    logic                  write_q, write_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                  rsp_err_q, rsp_err_d;

    logic                  cmd_err;
    logic                  poll_hit;
    logic [DATA_WIDTH-1:0] rmw_data;

    assign bus.cmd_ready = (state_q == ST_IDLE);
    assign bus.rsp_valid = (state_q == ST_RSP);
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.ADDRESS   = address_q;
    assign bus.WRITE     = write_q;
    assign bus.WDATA     = wdata_q;

    // Commands rejected up front: unknown opcode, unmapped address, or any
    // write-type operation aimed at the read-only input register.
    assign cmd_err = (bus.cmd_op > 3'd5) ||
                     !legal_addr(64'(bus.cmd_addr)) ||
                     ((64'(bus.cmd_addr) == GPIO_IN_ADDR) &&
                      (bus.cmd_op inside {OP_WRITE, OP_SET, OP_CLR, OP_TOGGLE}));

    assign poll_hit = ((bus.RDATA & mask_q) == (data_q & mask_q));
    assign rmw_data = DATA_WIDTH'(rmw_value(gpio_op_e'(op_q), 64'(bus.RDATA),
                                            64'(mask_q)));

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        mask_d     = mask_q;
        data_d     = data_q;
        cnt_d      = cnt_q;
        address_d  = address_q;
        write_d    = 1'b0;
        wdata_d    = wdata_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    op_d   = bus.cmd_op;
                    mask_d = bus.cmd_mask;
                    data_d = bus.cmd_data;
                    cnt_d  = '0;
                    if (cmd_err) begin
                        state_d    = ST_RSP;
                        rsp_err_d  = 1'b1;
                        rsp_data_d = '0;
                    end else begin
                        address_d = bus.cmd_addr;
                        rsp_err_d = 1'b0;
                        if (bus.cmd_op == OP_WRITE) begin
                            state_d = ST_WR;
                            write_d = 1'b1;
                            wdata_d = bus.cmd_data;
                        end else begin
                            state_d = ST_RD_ADDR;
                        end
                    end
                end
            end

            // Address is on the bus this cycle; the slave answers next cycle.
            ST_RD_ADDR: state_d = ST_RD_CAP;

            ST_RD_CAP: begin
                case (op_q)
                    OP_READ: begin
                        rsp_data_d = bus.RDATA;
                        state_d    = ST_RSP;
                    end
                    OP_POLL: begin
                        if (poll_hit || (cnt_q == POLL_LAST)) begin
                            rsp_data_d = bus.RDATA;
                            rsp_err_d  = !poll_hit;
                            state_d    = ST_RSP;
                        end else begin
                            cnt_d   = cnt_q + CNT_W'(1);
                            state_d = ST_RD_ADDR;
                        end
                    end
                    default: begin
                        wdata_d = rmw_data;
                        write_d = 1'b1;
                        state_d = ST_WR;
                    end
                endcase
            end

            // WRITE is registered from write_d, so it is high exactly in WR.
            ST_WR: begin
                rsp_data_d = wdata_q;
                state_d    = ST_RSP;
            end

            ST_RSP: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            op_q       <= '0;
            mask_q     <= '0;
            data_q     <= '0;
            cnt_q      <= '0;
            address_q  <= '0;
            write_q    <= 1'b0;
            wdata_q    <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            mask_q     <= mask_d;
            data_q     <= data_d;
            cnt_q      <= cnt_d;
            address_q  <= address_d;
            write_q    <= write_d;
            wdata_q    <= wdata_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_gpio_bus_master.sv
// -----------------------------------------------------------------------------
// tb_gpio_bus_master
//   Drives gpio_bus_master with directed and random commands against a simple
//   GPIO register block, and predicts every response, its latency and its bus
//   write activity from the command rules.
// -----------------------------------------------------------------------------
module tb_gpio_bus_master;
    import gpio_pkg::*;

    localparam int PMAX = 4;

    logic clk;
    logic rst_n;

    gpio_bus_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus();

    gpio_bus_master #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .POLL_MAX   (PMAX)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // GPIO register block: registered read data, OUT and DIR writable.
    logic [31:0] gpio_in  = 32'h0;
    logic [31:0] slv_out  = 32'h0;
    logic [31:0] slv_dir  = 32'h0;

    always @(posedge clk) begin
        if (bus.WRITE) begin
            if (bus.ADDRESS == 32'h4) slv_out <= bus.WDATA;
            if (bus.ADDRESS == 32'h8) slv_dir <= bus.WDATA;
        end
        case (bus.ADDRESS)
            32'h0:   bus.RDATA <= gpio_in;
            32'h4:   bus.RDATA <= slv_out;
            32'h8:   bus.RDATA <= slv_dir;
            default: bus.RDATA <= 32'hDEAD_BEEF;
        endcase
    end

    int vectors     = 0;
    int miscompares = 0;

    // Reference view of the register contents.
    logic [31:0] m_out = 32'h0;
    logic [31:0] m_dir = 32'h0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected outcome of one command: response, error, cycles from accept to
    // rsp_valid, and how many cycles WRITE is high.
    task automatic model_exec(input logic [2:0] op, input logic [31:0] addr,
                              input logic [31:0] data, input logic [31:0] mask,
                              output logic [31:0] d, output logic e,
                              output int lat, output int wr);
        logic [31:0] cur;
        bit mapped;
        mapped = (addr == 32'h0) || (addr == 32'h4) || (addr == 32'h8);
        cur    = (addr == 32'h0) ? gpio_in : (addr == 32'h4) ? m_out : m_dir;
        d = 32'h0; e = 1'b0; lat = 1; wr = 0;
        if (op > 3'd5 || !mapped || (addr == 32'h0 && op >= 3'd1 && op <= 3'd4)) begin
            e = 1'b1;
        end else begin
            case (op)
                3'd0: begin d = cur; lat = 3; end
                3'd1: begin d = data; lat = 2; wr = 1; end
                3'd2: begin d = cur | mask;  lat = 4; wr = 1; end
                3'd3: begin d = cur & ~mask; lat = 4; wr = 1; end
                3'd4: begin d = cur ^ mask;  lat = 4; wr = 1; end
                default: begin
                    // Input is constant during a poll: either the first read
                    // matches or all PMAX reads are spent.
                    d = cur;
                    if ((cur & mask) == (data & mask)) lat = 3;
                    else begin lat = 2 * PMAX + 1; e = 1'b1; end
                end
            endcase
            if (wr == 1) begin
                if (addr == 32'h4) m_out = d;
                if (addr == 32'h8) m_dir = d;
            end
        end
    endtask

    task automatic run_cmd(input logic [2:0] op, input logic [31:0] addr,
                           input logic [31:0] data, input logic [31:0] mask,
                           input int hold);
        logic [31:0] exp_d;
        logic        exp_e;
        int          exp_lat, exp_wr, lat, wr_cycles;
        bit          seen;
        model_exec(op, addr, data, mask, exp_d, exp_e, exp_lat, exp_wr);
        @(negedge clk);
        check("cmd_ready_idle", bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_addr  = addr;
        bus.cmd_data  = data;
        bus.cmd_mask  = mask;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        lat = 0; wr_cycles = 0; seen = 0;
        for (int i = 0; i < 3 * PMAX + 10 && !seen; i++) begin
            @(negedge clk);
            lat++;
            if (bus.WRITE) begin
                wr_cycles++;
                check("wr_address", bus.ADDRESS, addr);
                check("wr_wdata", bus.WDATA, exp_d);
            end
            if (bus.rsp_valid) seen = 1;
        end
        check("rsp_seen", seen, 1);
        if (!seen) return;
        check("rsp_latency", lat, exp_lat);
        check("write_cycles", wr_cycles, exp_wr);
        check("rsp_data", bus.rsp_data, exp_d);
        check("rsp_err", bus.rsp_err, exp_e);
        check("busy_ready", bus.cmd_ready, 0);
        for (int i = 0; i < hold; i++) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_op    = 3'($urandom_range(0, 7));
            bus.cmd_addr  = 32'h4;
            bus.cmd_data  = $urandom;
            @(negedge clk);
            check("hold_valid", bus.rsp_valid, 1);
            check("hold_data", bus.rsp_data, exp_d);
            check("hold_err", bus.rsp_err, exp_e);
            check("hold_ready", bus.cmd_ready, 0);
            check("hold_write", bus.WRITE, 0);
        end
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check("rsp_drop", bus.rsp_valid, 0);
        check("ready_after", bus.cmd_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

    logic [2:0]  r_op;
    logic [31:0] r_addr, r_data, r_mask;
    int          r_sel;
    bit          found;

    initial begin
        rst_n         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 3'd0;
        bus.cmd_addr  = 32'h0;
        bus.cmd_data  = 32'h0;
        bus.cmd_mask  = 32'h0;
        bus.rsp_ready = 1'b0;
        #1;
        check("rst_address", bus.ADDRESS, 0);
        check("rst_write", bus.WRITE, 0);
        check("rst_wdata", bus.WDATA, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_err", bus.rsp_err, 0);
        check("rst_rsp_data", bus.rsp_data, 0);
        check("rst_cmd_ready", bus.cmd_ready, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Write then read back OUT
        run_cmd(3'd1, 32'h4, 32'hA5A5_0000, 32'h0, 0);
        run_cmd(3'd0, 32'h4, 32'h0, 32'h0, 0);

        // Bit operations with read-back
        run_cmd(3'd1, 32'h4, 32'h0000_00F0, 32'h0, 0);
        run_cmd(3'd2, 32'h4, 32'h0, 32'h0F, 0);
        run_cmd(3'd0, 32'h4, 32'h0, 32'h0, 0);
        run_cmd(3'd3, 32'h4, 32'h0, 32'h30, 0);
        run_cmd(3'd0, 32'h4, 32'h0, 32'h0, 0);
        run_cmd(3'd4, 32'h4, 32'h0, 32'hFF, 0);
        run_cmd(3'd0, 32'h4, 32'h0, 32'h0, 0);
        check("out_final", slv_out, 32'h30);

        // Poll: immediate match, then timeout
        gpio_in = 32'h1;
        run_cmd(3'd5, 32'h0, 32'h1, 32'h1, 0);
        gpio_in = 32'h0;
        run_cmd(3'd5, 32'h0, 32'h1, 32'h1, 0);

        // Rejected commands
        run_cmd(3'd1, 32'h0, 32'h1234_5678, 32'h0, 0);
        run_cmd(3'd0, 32'hC, 32'h0, 32'h0, 0);
        run_cmd(3'd7, 32'h4, 32'h0, 32'h0, 0);
        check("out_untouched", slv_out, 32'h30);

        // Response back-pressure with a competing command
        run_cmd(3'd2, 32'h8, 32'h0, 32'h0000_0101, 5);

        // Random commands
        for (int k = 0; k < 40; k++) begin
            r_op    = 3'($urandom_range(0, 7));
            r_sel   = $urandom_range(0, 4);
            r_addr  = (r_sel == 0) ? 32'h0 : (r_sel == 1) ? 32'h4 :
                      (r_sel == 2) ? 32'h8 : (r_sel == 3) ? 32'hC : $urandom;
            r_data  = $urandom;
            r_mask  = $urandom;
            gpio_in = $urandom;
            if ($urandom_range(0, 1) == 1) r_data = gpio_in ^ ($urandom & ~r_mask);
            run_cmd(r_op, r_addr, r_data, r_mask, $urandom_range(0, 3));
        end

        // Reset in the write cycle of a read-modify-write
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 3'd2;
        bus.cmd_addr  = 32'h4;
        bus.cmd_mask  = 32'hFFFF_0000;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (bus.WRITE) found = 1;
        end
        check("rmw_wr_reached", found, 1);
        rst_n = 1'b0;
        #1;
        check("rst_write_async", bus.WRITE, 0);
        check("rst_ready_async", bus.cmd_ready, 1);
        check("rst_rsp_async", bus.rsp_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_rsp", bus.rsp_valid, 0);
            check("post_rst_ready", bus.cmd_ready, 1);
        end
        run_cmd(3'd0, 32'h4, 32'h0, 32'h0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/gpio_bus_master.md
Name: gpio_bus_master

Overview:
- Initiator for the GPIO register bus (ADDRESS/WRITE/WDATA/RDATA); drives the GPIO register block from a host command stream.
- Converts valid/ready host commands into single-cycle bus writes, 1-cycle-latency bus reads, read-modify-write bit ops and a bounded poll.
- Returns one response per command on a valid/ready response channel.
- Sits between the CPU-side command fabric and the GPIO block.

Parameters:
- ADDR_WIDTH, 32, bus address width.
- DATA_WIDTH, 32, bus and GPIO data width.
- POLL_MAX, 1024, maximum POLL read iterations before timeout (≥1).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_op  in  3  opcode: 0 READ, 1 WRITE, 2 SET, 3 CLR, 4 TOGGLE, 5 POLL, 6–7 illegal.
- cmd_addr  in  ADDR_WIDTH  register address.
- cmd_data  in  DATA_WIDTH  write data (WRITE) or expected value (POLL).
- cmd_mask  in  DATA_WIDTH  bit mask for SET/CLR/TOGGLE/POLL.
- rsp_valid  out  1  response valid; held until rsp_ready.
- rsp_ready  in  1  response consumed.
- rsp_data  out  DATA_WIDTH  read value, or the post-write register value for RMW ops.
- rsp_err  out  1  error flag.
- ADDRESS  out  ADDR_WIDTH  bus address (registered).
- WRITE  out  1  bus write strobe (registered).
- WDATA  out  DATA_WIDTH  bus write data (registered).
- RDATA  in  DATA_WIDTH  bus read data; valid the cycle after a read address is presented.

Behaviour:
- Register map: 0x000 IN (read-only), 0x004 OUT, 0x008 DIR.
- Reset values: ADDRESS=0, WRITE=0, WDATA=0, rsp_valid=0, rsp_err=0, rsp_data=0. State is IDLE, so cmd_ready=1 out of reset.
- Reset mid-operation: immediate return to IDLE, WRITE drops asynchronously, poll counter cleared, any pending response discarded.
- cmd_ready = (state==IDLE). Exactly one command is in flight; no new accept while rsp_valid is high.
- Idle bus: WRITE=0, ADDRESS holds its last value; the slave's idle reads are harmless.
- FSM states: IDLE, RD_ADDR, RD_CAP, WR, RSP.
- Accept cycle T, legal READ: T+1 RD_ADDR (ADDRESS=addr, WRITE=0); T+2 RD_CAP, RDATA sampled into rsp_data; T+3 RSP with rsp_valid=1.
- WRITE: T+1 WR (WRITE=1, ADDRESS, WDATA=cmd_data) for exactly one cycle; T+2 RSP, rsp_data=cmd_data.
- SET/CLR/TOGGLE: read as above (T+1, T+2). T+3 WR with WDATA computed from the sampled value r:
  - SET: r|mask
  - CLR: r&~mask
  - TOGGLE: r^mask
  - T+4 RSP, rsp_data=WDATA.
- POLL: repeat RD_ADDR/RD_CAP pairs. Match condition is (RDATA&mask)==(cmd_data&mask).
  - Match at iteration n (1-based): RSP, err=0, rsp_data=RDATA.
  - n==POLL_MAX with no match: RSP, err=1, rsp_data=last RDATA.
  - Counter width $clog2(POLL_MAX+1).
- Errors are detected in the accept cycle. No bus write is issued; RSP is entered at T+1 with rsp_err=1, rsp_data=0. Error cases:
  - illegal opcode;
  - address not in {0x000, 0x004, 0x008};
  - WRITE/SET/CLR/TOGGLE to 0x000.
- READ/POLL of 0x000 is legal.
- RSP: rsp_valid, rsp_data and rsp_err stay stable until rsp_ready. rsp_valid && rsp_ready moves to IDLE, so cmd_ready=1 the next cycle. Back-to-back throughput is therefore one command per (latency+1) cycles.
- WRITE is asserted only in WR and never in any other state.

Decomposition:
- Package gpio_pkg holds:
  - opcode enum gpio_op_e;
  - register address localparams GPIO_IN_ADDR, GPIO_OUT_ADDR, GPIO_DIR_ADDR;
  - FSM state enum;
  - function legal_addr().
- No sub-module. The RMW data path is a single combinational function in the package.

Test Plan:
- WRITE OUT=0xA5A5_0000, then READ 0x004 → WRITE high for exactly one cycle; read rsp_data=0xA5A5_0000, err=0, rsp_valid 3 cycles after accept.
- OUT=0x0000_00F0; SET mask 0x0F, CLR mask 0x30, TOGGLE mask 0xFF → rsp_data 0xFF, 0xCF, 0x30; read-back of OUT matches each.
- GPIO_IN=0x1 stuck, POLL 0x000 mask 0x1 data 0x1 → match on iteration 1, err=0. GPIO_IN=0, POLL_MAX=4 → err=1 after 4 read pairs (accept → rsp_valid = 9 cycles).
- WRITE to 0x000, READ 0x00C, op=7 → each gives err=1, rsp_data=0, rsp_valid at T+1, WRITE never asserted.
- rsp_ready held low 5 cycles → rsp fields stable, cmd_ready=0, new cmd_valid not accepted.
- rst_n pulse during RMW WR cycle → WRITE=0 immediately, cmd_ready=1 after release, no response emitted.
